// File: rtl/accum_stage_if.sv
// Operand/result bundle for accum_stage.
// The master side drives the operand stream and controls; the slave side is the accumulator.
interface accum_stage_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
);
    logic             CE;
    logic             START;
    logic [LEN_W-1:0] ACC_LEN;
    logic             IN_VALID;
    logic [WIDTH-1:0] OPERAND;
    logic             ADDSUB;
    logic             ADDER_CI;
    logic [WIDTH-1:0] ACC_OUT;
    logic             CO;
    logic             COCAS;
    logic             OVF;
    logic             OUT_VALID;
    logic             BUSY;

    modport master (
        output CE, START, ACC_LEN, IN_VALID, OPERAND, ADDSUB, ADDER_CI,
        input  ACC_OUT, CO, COCAS, OVF, OUT_VALID, BUSY
    );

    modport slave (
        input  CE, START, ACC_LEN, IN_VALID, OPERAND, ADDSUB, ADDER_CI,
        output ACC_OUT, CO, COCAS, OVF, OUT_VALID, BUSY
    );
endinterface

// File: rtl/accum_stage.sv
// Accumulates ACC_LEN add/sub samples per run and publishes the sum, carry and sticky overflow.
// Latency: result and OUT_VALID registered one cycle after the last accepted sample.
// Backpressure: none; IN_VALID gaps stall the run and CE low freezes every register.
module accum_stage #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input logic         CLK,
    input logic         RST_N,
    accum_stage_if.slave io
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [LEN_W-1:0] cnt_q,       cnt_d;
    logic             ovf_int_q,   ovf_int_d;
    logic [WIDTH-1:0] acc_out_q,   acc_out_d;
    logic             co_q,        co_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic             add_ovf;

    always_comb begin
        addend  = io.ADDSUB ? ~io.OPERAND : io.OPERAND;
        sum     = {1'b0, acc_q} + {1'b0, addend} + {{WIDTH{1'b0}}, io.ADDER_CI};
        add_ovf = (acc_q[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_int_d   = ovf_int_q;
        acc_out_d   = acc_out_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        // START wins in every state, which silently abandons any run in flight.
        if (io.START) begin
            state_d   = ST_ACCUM;
            acc_d     = '0;
            cnt_d     = (io.ACC_LEN == '0) ? LEN_W'(1) : io.ACC_LEN;
            ovf_int_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (io.IN_VALID) begin
                        acc_d     = sum[WIDTH-1:0];
                        cnt_d     = cnt_q - LEN_W'(1);
                        ovf_int_d = ovf_int_q | add_ovf;
                        if (cnt_q == LEN_W'(1)) begin
                            acc_out_d   = sum[WIDTH-1:0];
                            co_d        = sum[WIDTH];
                            ovf_d       = ovf_int_q | add_ovf;
                            out_valid_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_int_q   <= 1'b0;
            acc_out_q   <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (io.CE) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_int_q   <= ovf_int_d;
            acc_out_q   <= acc_out_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.ACC_OUT   = acc_out_q;
    assign io.CO        = co_q;
    assign io.COCAS     = co_q;
    assign io.OVF       = ovf_q;
    assign io.OUT_VALID = out_valid_q;
    assign io.BUSY      = (state_q == ST_ACCUM);
endmodule

// File: doc/accum_stage.md
ACCUM_STAGE -- requirements
Module: accum_stage

Interface
REQ-001 Parameter WIDTH, default 16, is the adder/accumulator width in bits.
REQ-002 Parameter LEN_W, default 8, is the sample-count width.
REQ-003 Port CLK, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port RST_N, input, 1, is the reset: asynchronous, active-low.
REQ-005 Port CE, input, 1, is the clock enable; when low, all state holds.
REQ-006 Port START, input, 1, starts a new accumulation run.
REQ-007 Port ACC_LEN, input, LEN_W, gives the number of samples per run, sampled with START.
REQ-008 Port IN_VALID, input, 1, qualifies OPERAND.
REQ-009 Port OPERAND, input, WIDTH, is the sample to accumulate.
REQ-010 Port ADDSUB, input, 1, selects the operation: 0 = add, 1 = subtract.
REQ-011 Port ADDER_CI, input, 1, is the carry-in from the carry-in mux stage.
REQ-012 Port ACC_OUT, output, WIDTH, is the registered run result.
REQ-013 Port CO, output, 1, is the registered carry-out of the final add of a run.
REQ-014 Port COCAS, output, 1, is the cascade carry; it equals CO.
REQ-015 Port OVF, output, 1, is the sticky signed-overflow flag of the last run.
REQ-016 Port OUT_VALID, output, 1, is a one-cycle result strobe.
REQ-017 Port BUSY, output, 1, is high while in ACCUM.

Function
REQ-018 All behaviour below applies only in cycles with CE=1; when CE=0, every register, including the state and the OUT_VALID register, holds its value.
REQ-019 The FSM has three states, IDLE, ACCUM and DONE, and transitions as follows:
- IDLE -> ACCUM on START.
- ACCUM -> DONE when the last sample is accepted.
- DONE -> IDLE after one cycle, or DONE -> ACCUM if START is high.
REQ-020 On START in any state:
- acc <= 0;
- cnt <= (ACC_LEN==0 ? 1 : ACC_LEN);
- ovf_int <= 0;
- state <= ACCUM;
- any run in progress is aborted without asserting OUT_VALID.
REQ-021 In ACCUM with IN_VALID=1 and START=0:
- sum = acc + (ADDSUB ? ~OPERAND : OPERAND) + ADDER_CI, computed WIDTH+1 bits wide;
- acc <= sum[WIDTH-1:0];
- cnt decrements by 1.
REQ-022 Subtraction acc-OPERAND is exact only when ADDER_CI=1; the block does not force the carry-in.
REQ-023 Signed overflow occurs when both addends have equal MSBs and the result MSB differs; any such add sets ovf_int, which stays set for the rest of the run.
REQ-024 The accept with cnt==1 is the last sample; on it:
- ACC_OUT <= sum[WIDTH-1:0];
- CO <= sum[WIDTH];
- OVF <= ovf_int OR this add's overflow;
- state <= DONE.
REQ-025 In ACCUM with IN_VALID=0, acc and cnt hold.
REQ-026 IN_VALID is ignored in IDLE and in DONE.
REQ-027 OUT_VALID is registered and is high exactly during the DONE cycle, i.e. the cycle after the last sample is accepted.
REQ-028 Latency: ACC_OUT is valid one cycle after the last accepted sample and holds until the next run completes.
REQ-029 ACC_OUT, CO and OVF are not updated on an aborted run.
REQ-030 Accumulation wraps modulo 2^WIDTH with no saturation.
REQ-031 Intermediate carry-outs are discarded; only the final carry reaches CO.
REQ-032 BUSY = (state==ACCUM), driven combinationally from the state register.

Reset
REQ-033 While RST_N is low, the following hold immediately, independent of CLK and CE:
- state=IDLE, acc=0, cnt=0, ovf_int=0;
- ACC_OUT=0, CO=0, COCAS=0, OVF=0, OUT_VALID=0, BUSY=0.
REQ-034 Reset asserted mid-run discards the run; after RST_N rises, no OUT_VALID occurs until a new START.

Verification
REQ-035 Basic add run: WIDTH=16, START with ACC_LEN=3; samples 1, 2, 3 with ADDSUB=0, CI=0 -> ACC_OUT=6, CO=0, OVF=0, OUT_VALID high for one cycle, exactly one cycle after the 3rd sample.
REQ-036 Subtract run: ACC_LEN=2; samples 10 (ADDSUB=0, CI=0) then 3 (ADDSUB=1, CI=1) -> ACC_OUT=7, CO=1.
REQ-037 Overflow and wrap: ACC_LEN=2; samples 0x7FFF, then 0x0001 -> ACC_OUT=0x8000, OVF=1, CO=0; the next clean run clears OVF.
REQ-038 Stall and clock enable: IN_VALID gaps and CE low for 5 cycles mid-run -> same result as the gapless run, with OUT_VALID delayed accordingly.
REQ-039 Abort and reset: START mid-run restarts with no OUT_VALID; RST_N low mid-run -> all outputs 0 asynchronously; ACC_LEN=0 -> completes after 1 sample.
